// File: rtl/hilo_commit_pipe_pkg.sv
// Shared HI/LO definitions: bus widths, enable encodings and reset constants
// used by the commit pipe and its slot registers.
package hilo_commit_pipe_pkg;

  localparam int DATA_BUS = 32;
  localparam int HILO_SLOT_BUS = 1 + 2 * DATA_BUS;

  localparam logic WRITE_ENABLE  = 1'b1;
  localparam logic WRITE_DISABLE = 1'b0;
  localparam logic RST_ENABLE    = 1'b1;

  localparam logic [DATA_BUS-1:0] ZERO_WORD = '0;

endpackage

// File: rtl/hilo_commit_pipe_slot.sv
// One pipeline slot {en, hi, lo}: loads, holds, or is killed/bubbled
// each cycle.
module hilo_commit_pipe_slot
  import hilo_commit_pipe_pkg::*;
#(
  parameter int DATA_W = DATA_BUS
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              kill,
  input  logic              bubble,
  input  logic              nxt_en,
  input  logic [DATA_W-1:0] nxt_hi,
  input  logic [DATA_W-1:0] nxt_lo,
  output logic              en,
  output logic [DATA_W-1:0] hi,
  output logic [DATA_W-1:0] lo
);

  // A killed load still captures data; only the enable is dropped.
  always_ff @(posedge clk) begin
    if (rst == RST_ENABLE) begin
      en <= WRITE_DISABLE;
      hi <= '0;
      lo <= '0;
    end else if (load) begin
      en <= nxt_en & ~kill;
      hi <= nxt_hi;
      lo <= nxt_lo;
    end else if (kill || bubble) begin
      en <= WRITE_DISABLE;
    end
  end

endmodule

// File: rtl/hilo_commit_pipe.sv
// HI/LO write pipe: carries EX writes through MEM and WB slots, commits at WB
// and forwards the youngest in-flight pair back to EX.
module hilo_commit_pipe
  import hilo_commit_pipe_pkg::*;
#(
  parameter int DATA_W = DATA_BUS
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ex_write_hilo_en,
  input  logic [DATA_W-1:0] ex_write_hi_data,
  input  logic [DATA_W-1:0] ex_write_lo_data,
  input  logic              stall_mem,
  input  logic              flush,
  output logic [DATA_W-1:0] hi_val_mux_data,
  output logic [DATA_W-1:0] lo_val_mux_data,
  output logic [DATA_W-1:0] hi_arch,
  output logic [DATA_W-1:0] lo_arch,
  output logic              hilo_busy,
  output logic              commit_pulse
);

  logic              m_en, w_en;
  logic [DATA_W-1:0] m_hi, m_lo, w_hi, w_lo;
  logic [DATA_W-1:0] hi_r, lo_r;
  logic              m_load, w_load;

  // Flush beats stall: MEM is emptied rather than held, and WB takes
  // the (killed) MEM contents instead of a plain bubble.
  assign m_load = ~flush & ~stall_mem;
  assign w_load = ~stall_mem | flush;

  // ---- MEM slot ----
  hilo_commit_pipe_slot #(.DATA_W(DATA_W)) u_mem_slot (
    .clk    (clk),
    .rst    (rst),
    .load   (m_load),
    .kill   (flush),
    .bubble (1'b0),
    .nxt_en (ex_write_hilo_en),
    .nxt_hi (ex_write_hi_data),
    .nxt_lo (ex_write_lo_data),
    .en     (m_en),
    .hi     (m_hi),
    .lo     (m_lo)
  );

  // ---- WB slot ----
  hilo_commit_pipe_slot #(.DATA_W(DATA_W)) u_wb_slot (
    .clk    (clk),
    .rst    (rst),
    .load   (w_load),
    .kill   (flush),
    .bubble (stall_mem),
    .nxt_en (m_en),
    .nxt_hi (m_hi),
    .nxt_lo (m_lo),
    .en     (w_en),
    .hi     (w_hi),
    .lo     (w_lo)
  );

  // ---- commit to architectural HI/LO ----
  always_ff @(posedge clk) begin
    if (rst == RST_ENABLE) begin
      hi_r         <= '0;
      lo_r         <= '0;
      commit_pulse <= WRITE_DISABLE;
    end else begin
      commit_pulse <= w_en;
      if (w_en == WRITE_ENABLE) begin
        hi_r <= w_hi;
        lo_r <= w_lo;
      end
    end
  end

  always_comb begin
    hi_val_mux_data = hi_r;
    lo_val_mux_data = lo_r;
    if (m_en) begin
      hi_val_mux_data = m_hi;
      lo_val_mux_data = m_lo;
    end else if (w_en) begin
      hi_val_mux_data = w_hi;
      lo_val_mux_data = w_lo;
    end
  end

  assign hi_arch   = hi_r;
  assign lo_arch   = lo_r;
  assign hilo_busy = m_en | w_en;

endmodule

// File: tb/tb_hilo_commit_pipe.sv
// Directed bench for the HI/LO commit pipe with hand-computed expectations.
module tb_hilo_commit_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic        ex_write_hilo_en;
  logic [31:0] ex_write_hi_data;
  logic [31:0] ex_write_lo_data;
  logic        stall_mem;
  logic        flush;
  logic [31:0] hi_val_mux_data;
  logic [31:0] lo_val_mux_data;
  logic [31:0] hi_arch;
  logic [31:0] lo_arch;
  logic        hilo_busy;
  logic        commit_pulse;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  hilo_commit_pipe #(.DATA_W(32)) dut (
    .clk              (clk),
    .rst              (rst),
    .ex_write_hilo_en (ex_write_hilo_en),
    .ex_write_hi_data (ex_write_hi_data),
    .ex_write_lo_data (ex_write_lo_data),
    .stall_mem        (stall_mem),
    .flush            (flush),
    .hi_val_mux_data  (hi_val_mux_data),
    .lo_val_mux_data  (lo_val_mux_data),
    .hi_arch          (hi_arch),
    .lo_arch          (lo_arch),
    .hilo_busy        (hilo_busy),
    .commit_pulse     (commit_pulse)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [31:0] mhi, input logic [31:0] mlo,
                         input logic [31:0] ahi, input logic [31:0] alo,
                         input logic busy, input logic cp);
    chk({tag, "_mux_hi"}, hi_val_mux_data, mhi);
    chk({tag, "_mux_lo"}, lo_val_mux_data, mlo);
    chk({tag, "_arch_hi"}, hi_arch, ahi);
    chk({tag, "_arch_lo"}, lo_arch, alo);
    chk({tag, "_busy"}, {31'd0, hilo_busy}, {31'd0, busy});
    chk({tag, "_commit"}, {31'd0, commit_pulse}, {31'd0, cp});
  endtask

  // Advance one edge; inputs are changed and outputs sampled 1ns after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic req(input logic en, input logic [31:0] hi, input logic [31:0] lo);
    ex_write_hilo_en = en;
    ex_write_hi_data = hi;
    ex_write_lo_data = lo;
  endtask

  initial begin
    rst = 1'b1;
    stall_mem = 1'b0;
    flush = 1'b0;
    req(1'b1, 32'hDEADBEEF, 32'hCAFEF00D);
    step();
    step();
    chk_all("reset", 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);

    rst = 1'b0;
    req(1'b0, 32'h0, 32'h0);
    step(); step(); step();
    chk_all("idle", 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);

    // single write
    req(1'b1, 32'h11111111, 32'h22222222);
    step();
    req(1'b0, 32'h0, 32'h0);
    chk_all("single_n", 32'h11111111, 32'h22222222, 32'h0, 32'h0, 1'b1, 1'b0);
    step();
    chk_all("single_n1", 32'h11111111, 32'h22222222, 32'h0, 32'h0, 1'b1, 1'b0);
    step();
    chk_all("single_n2", 32'h11111111, 32'h22222222, 32'h11111111, 32'h22222222, 1'b0, 1'b1);
    step();
    chk_all("single_n3", 32'h11111111, 32'h22222222, 32'h11111111, 32'h22222222, 1'b0, 1'b0);

    // back-to-back A then B
    req(1'b1, 32'h1, 32'h2);
    step();
    chk_all("b2b_n", 32'h1, 32'h2, 32'h11111111, 32'h22222222, 1'b1, 1'b0);
    req(1'b1, 32'h3, 32'h4);
    step();
    req(1'b0, 32'h0, 32'h0);
    chk_all("b2b_n1", 32'h3, 32'h4, 32'h11111111, 32'h22222222, 1'b1, 1'b0);
    step();
    chk_all("b2b_n2", 32'h3, 32'h4, 32'h1, 32'h2, 1'b1, 1'b1);
    step();
    chk_all("b2b_n3", 32'h3, 32'h4, 32'h3, 32'h4, 1'b0, 1'b1);
    step();
    chk_all("b2b_n4", 32'h3, 32'h4, 32'h3, 32'h4, 1'b0, 1'b0);

    // stall two cycles with A in MEM
    req(1'b1, 32'h5, 32'h6);
    step();
    req(1'b1, 32'hBAD0BAD0, 32'hBAD1BAD1);
    stall_mem = 1'b1;
    step();
    chk_all("stall_1", 32'h5, 32'h6, 32'h3, 32'h4, 1'b1, 1'b0);
    step();
    chk_all("stall_2", 32'h5, 32'h6, 32'h3, 32'h4, 1'b1, 1'b0);
    stall_mem = 1'b0;
    req(1'b0, 32'h0, 32'h0);
    step();
    chk_all("stall_3", 32'h5, 32'h6, 32'h3, 32'h4, 1'b1, 1'b0);
    step();
    chk_all("stall_4", 32'h5, 32'h6, 32'h5, 32'h6, 1'b0, 1'b1);
    step();
    chk_all("stall_5", 32'h5, 32'h6, 32'h5, 32'h6, 1'b0, 1'b0);

    // flush with A in WB and B in MEM
    req(1'b1, 32'h7, 32'h8);
    step();
    req(1'b1, 32'h9, 32'hA);
    step();
    req(1'b1, 32'hEEEEEEEE, 32'hFFFFFFFF);
    flush = 1'b1;
    step();
    flush = 1'b0;
    req(1'b0, 32'h0, 32'h0);
    chk_all("flush_n2", 32'h7, 32'h8, 32'h7, 32'h8, 1'b0, 1'b1);
    step();
    chk_all("flush_n3", 32'h7, 32'h8, 32'h7, 32'h8, 1'b0, 1'b0);

    // flush and stall together with C held in MEM
    req(1'b1, 32'hC, 32'hD);
    step();
    req(1'b0, 32'h0, 32'h0);
    stall_mem = 1'b1;
    step();
    chk_all("fs_hold", 32'hC, 32'hD, 32'h7, 32'h8, 1'b1, 1'b0);
    flush = 1'b1;
    step();
    flush = 1'b0;
    stall_mem = 1'b0;
    chk_all("fs_flush", 32'h7, 32'h8, 32'h7, 32'h8, 1'b0, 1'b0);
    step(); step();
    chk_all("fs_after", 32'h7, 32'h8, 32'h7, 32'h8, 1'b0, 1'b0);

    // reset overrides stall and flush while a write is in flight
    req(1'b1, 32'h55, 32'h66);
    step();
    rst = 1'b1;
    stall_mem = 1'b1;
    flush = 1'b1;
    step();
    chk_all("rst_mid", 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);
    rst = 1'b0;
    stall_mem = 1'b0;
    flush = 1'b0;
    req(1'b0, 32'h0, 32'h0);
    step(); step();
    chk_all("rst_post", 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
